rv32im_muldiv_issue: RTL and testbench
======================================

Name: rv32im_muldiv_issue

Overview:
- Pipeline-side initiator for the multiply/divide unit.
- Accepts a decoded RV32M op from execute, latches operands, and drives the unit's request/busy/ready/writeback-ce handshake.
- Stalls the pipeline while the op is outstanding, then presents the result to the register-file writeback port with rd.
- Handles flush, rd==x0 and a hung-unit watchdog.

Parameters:
- XLEN, 32, datapath width.
- TIMEOUT_CYCLES, 64, max cycles in WAIT_BUSY plus WAIT_DONE before watchdog fires; counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk_i  in  1  clock.
- clear_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  pipeline flush; kills any outstanding op.
- issue_valid_i  in  1  execute presents an M-extension op.
- issue_ready_o  out  1  block can accept (state IDLE).
- funct3_i  in  3  operation code (MUL=000 … REMU=111).
- rd_i  in  5  destination register.
- rs1_i  in  XLEN  operand 1.
- rs2_i  in  XLEN  operand 2.
- stall_o  out  1  pipeline stall; high whenever state != IDLE.
- wb_valid_o  out  1  result valid for writeback.
- wb_rd_o  out  5  destination register.
- wb_data_o  out  XLEN  result.
- wb_ack_i  in  1  register file consumed result.
- error_o  out  1  sticky watchdog flag; cleared only by clear_i.
- md_clear_o  out  1  to unit clear_i.
- md_operation_o  out  3  to unit operation_i.
- md_operand1_o  out  XLEN  to unit operand1_i.
- md_operand2_o  out  XLEN  to unit operand2_i.
- md_data_ready_o  out  1  to unit data_ready_i.
- md_busy_i  in  1  from unit busy_o.
- md_data_ready_i  in  1  from unit data_ready_o.
- md_result_i  in  XLEN  from unit result_o.
- md_writeback_ce_o  out  1  to unit writeback_ce_i.

Behaviour:
- Reset (clear_i): state IDLE, all outputs 0 except issue_ready_o=1 and md_clear_o=1. The timeout counter, error_o and latched operand/rd/op registers are cleared.
- md_clear_o = clear_i OR a single-cycle registered pulse generated on flush_i.
- md_operation_o, md_operand1_o and md_operand2_o are driven from latched registers and are stable from SEND until IDLE.
- States:
  - IDLE: on issue_valid_i, latch funct3, rd, rs1, rs2.
    - rd_i==0: go to WB_DROP (1 cycle, no wb_valid_o), then IDLE.
    - otherwise: go to SEND.
  - SEND: md_data_ready_o=1 for exactly one cycle; go to WAIT_BUSY.
  - WAIT_BUSY: wait for md_busy_i=1, then go to WAIT_DONE. md_data_ready_o is never re-asserted.
  - WAIT_DONE: when md_busy_i=0 and md_data_ready_i=1, register md_result_i into wb_data_o and go to WB.
  - WB: wb_valid_o=1 and wb_rd_o/wb_data_o held stable until wb_ack_i. On the ack cycle, md_writeback_ce_o=1 for one cycle; next state IDLE.
- Latency, accept at cycle T:
  - md_data_ready_o at T+1.
  - Unit busy from T+2.
  - wb_valid_o one cycle after md_data_ready_i is seen.
  - issue_ready_o returns the cycle after wb_ack_i.
- issue_valid_i while not IDLE is ignored; stall_o guarantees the op is held upstream.
- flush_i in any state: next state IDLE, md_clear_o pulses, no wb_valid_o and no md_writeback_ce_o. flush_i has priority over wb_ack_i in the same cycle, and over issue_valid_i.
- Watchdog: counter runs in WAIT_BUSY and WAIT_DONE and resets on state entry from SEND. On reaching TIMEOUT_CYCLES:
  - set error_o, pulse md_clear_o;
  - go to WB with wb_data_o = all-ones, so the pipeline does not deadlock.
- clear_i mid-operation: immediate return to reset values, regardless of state.

Optional Feature:
- Macro MULDIV_RESULT_CACHE_EN.
- Defined: a single-entry cache {valid, funct3, op1, op2, result} is written on every WAIT_DONE completion.
  - In IDLE, an accepted op whose funct3/rs1/rs2 match a valid entry goes directly to WB with the cached result. No md_data_ready_o and no md_writeback_ce_o are issued.
  - The entry is invalidated on clear_i and on watchdog fire, but not on flush_i.
- Undefined: every op with rd!=0 goes through SEND; no cache storage exists.

Test Plan:
- DIVU rs1=100 rs2=7 rd=5, wb_ack_i tied high -> md_data_ready_o one cycle at T+1; then wb_valid_o with wb_rd_o=5, wb_data_o=14, and one md_writeback_ce_o pulse.
- REM rs1=0xFFFFFFF9 (-7) rs2=2 rd=3, wb_ack_i delayed 3 cycles -> wb_data_o=0xFFFFFFFF held for 4 cycles; stall_o high throughout; single md_writeback_ce_o on ack.
- MUL rs1=6 rs2=7 rd=0 -> no md_data_ready_o, no wb_valid_o; issue_ready_o back high 2 cycles after accept.
- DIV issued, flush_i asserted 5 cycles into WAIT_DONE -> md_clear_o one-cycle pulse, state IDLE next cycle, wb_valid_o never asserted.
- Bench unit holds md_busy_i=1 forever -> after TIMEOUT_CYCLES=64, error_o=1 (sticky), md_clear_o pulse, wb_valid_o with wb_data_o=0xFFFFFFFF.
- With MULDIV_RESULT_CACHE_EN: MUL 6*7 rd=1 then identical MUL rd=2 -> second op has no md_data_ready_o; wb_valid_o one cycle after accept with wb_data_o=42, wb_rd_o=2.

Source files
------------

// File: rtl/rv32im_muldiv_issue_if.sv
// Handshake bundle between the pipeline/execute side, the issue block and the mul/div unit.
interface rv32im_muldiv_issue_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush_i;
    logic            issue_valid_i;
    logic            issue_ready_o;
    logic [2:0]      funct3_i;
    logic [4:0]      rd_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            stall_o;
    logic            wb_valid_o;
    logic [4:0]      wb_rd_o;
    logic [XLEN-1:0] wb_data_o;
    logic            wb_ack_i;
    logic            error_o;
    logic            md_clear_o;
    logic [2:0]      md_operation_o;
    logic [XLEN-1:0] md_operand1_o;
    logic [XLEN-1:0] md_operand2_o;
    logic            md_data_ready_o;
    logic            md_busy_i;
    logic            md_data_ready_i;
    logic [XLEN-1:0] md_result_i;
    logic            md_writeback_ce_o;

    modport master (
        input  flush_i, issue_valid_i, funct3_i, rd_i, rs1_i, rs2_i, wb_ack_i,
        input  md_busy_i, md_data_ready_i, md_result_i,
        output issue_ready_o, stall_o, wb_valid_o, wb_rd_o, wb_data_o, error_o,
        output md_clear_o, md_operation_o, md_operand1_o, md_operand2_o,
        output md_data_ready_o, md_writeback_ce_o
    );

    modport slave (
        output flush_i, issue_valid_i, funct3_i, rd_i, rs1_i, rs2_i, wb_ack_i,
        output md_busy_i, md_data_ready_i, md_result_i,
        input  issue_ready_o, stall_o, wb_valid_o, wb_rd_o, wb_data_o, error_o,
        input  md_clear_o, md_operation_o, md_operand1_o, md_operand2_o,
        input  md_data_ready_o, md_writeback_ce_o
    );
endinterface

// File: rtl/rv32im_muldiv_issue.sv
// Pipeline-side issue/handshake FSM for the RV32M multiply/divide unit, with hang watchdog.
// Optional single-entry result cache enabled by defining MULDIV_RESULT_CACHE_EN.
module rv32im_muldiv_issue #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk_i,
    input  logic                   clear_i,
    rv32im_muldiv_issue_if.master  bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWaitBusy,
        StWaitDone,
        StWb,
        StWbDrop
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] op1_q, op2_q;
    logic [XLEN-1:0] wb_data_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_inc;
    logic            error_q;
    logic            clr_pulse_q;
    logic            from_cache_q;

    logic            in_wait;
    logic            done;
    logic            wd_fire;
    logic            accept;
    logic            rd_zero;
    logic            cache_hit;

    assign in_wait = (state_q == StWaitBusy) || (state_q == StWaitDone);
    assign done    = (state_q == StWaitDone) && !bus.md_busy_i && bus.md_data_ready_i;
    assign cnt_inc = cnt_q + 1'b1;
    // A real completion wins over the watchdog when both land in the same cycle.
    assign wd_fire = in_wait && !done && (cnt_inc == CntW'(TIMEOUT_CYCLES));
    assign accept  = (state_q == StIdle) && bus.issue_valid_i && !bus.flush_i;
    assign rd_zero = (bus.rd_i == 5'd0);

`ifdef MULDIV_RESULT_CACHE_EN
    logic            cache_valid_q;
    logic [2:0]      cache_op_q;
    logic [XLEN-1:0] cache_op1_q, cache_op2_q, cache_res_q;

    assign cache_hit = cache_valid_q && (cache_op_q == bus.funct3_i) &&
                       (cache_op1_q == bus.rs1_i) && (cache_op2_q == bus.rs2_i);

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            cache_valid_q <= 1'b0;
            cache_op_q    <= '0;
            cache_op1_q   <= '0;
            cache_op2_q   <= '0;
            cache_res_q   <= '0;
        end else if (!bus.flush_i) begin
            if (done) begin
                cache_valid_q <= 1'b1;
                cache_op_q    <= op_q;
                cache_op1_q   <= op1_q;
                cache_op2_q   <= op2_q;
                cache_res_q   <= bus.md_result_i;
            end else if (wd_fire) begin
                cache_valid_q <= 1'b0;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.issue_valid_i) begin
                        if (rd_zero) begin
                            state_d = StWbDrop;
                        end else if (cache_hit) begin
                            state_d = StWb;
                        end else begin
                            state_d = StSend;
                        end
                    end
                end
                StSend:     state_d = StWaitBusy;
                StWaitBusy: begin
                    if (wd_fire) begin
                        state_d = StWb;
                    end else if (bus.md_busy_i) begin
                        state_d = StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (done || wd_fire) begin
                        state_d = StWb;
                    end
                end
                StWb: begin
                    if (bus.wb_ack_i) begin
                        state_d = StIdle;
                    end
                end
                StWbDrop:   state_d = StIdle;
                default:    state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bus.issue_ready_o     = (state_q == StIdle);
        bus.stall_o           = (state_q != StIdle);
        bus.md_data_ready_o   = (state_q == StSend);
        bus.wb_valid_o        = (state_q == StWb) && !bus.flush_i;
        // Cached results never reached the unit, so there is nothing for it to retire.
        bus.md_writeback_ce_o = (state_q == StWb) && bus.wb_ack_i && !bus.flush_i &&
                                !from_cache_q;
        bus.md_clear_o        = clear_i || clr_pulse_q;
        bus.md_operation_o    = op_q;
        bus.md_operand1_o     = op1_q;
        bus.md_operand2_o     = op2_q;
        bus.wb_rd_o           = rd_q;
        bus.wb_data_o         = wb_data_q;
        bus.error_o           = error_q;
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            op_q         <= '0;
            rd_q         <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            wb_data_q    <= '0;
            cnt_q        <= '0;
            error_q      <= 1'b0;
            clr_pulse_q  <= 1'b0;
            from_cache_q <= 1'b0;
        end else begin
            clr_pulse_q <= bus.flush_i || wd_fire;
            if (accept) begin
                op_q         <= bus.funct3_i;
                rd_q         <= bus.rd_i;
                op1_q        <= bus.rs1_i;
                op2_q        <= bus.rs2_i;
                from_cache_q <= cache_hit && !rd_zero;
`ifdef MULDIV_RESULT_CACHE_EN
                if (cache_hit && !rd_zero) begin
                    wb_data_q <= cache_res_q;
                end
`endif
            end
            if (state_q == StSend) begin
                cnt_q <= '0;
            end else if (in_wait) begin
                cnt_q <= cnt_inc;
            end
            if (!bus.flush_i) begin
                if (done) begin
                    wb_data_q <= bus.md_result_i;
                end else if (wd_fire) begin
                    wb_data_q <= '1;
                    error_q   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rv32im_muldiv_issue.sv
// Directed self-checking bench for rv32im_muldiv_issue with a small behavioural mul/div unit.
module tb_rv32im_muldiv_issue;
    logic clk;
    logic clear;

    rv32im_muldiv_issue_if #(.XLEN(32)) bus ();

    rv32im_muldiv_issue #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_i   (clk),
        .clear_i (clear),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural unit: busy from the cycle after data_ready, result after unit_lat cycles.
    logic [31:0] unit_result;
    int          unit_lat;
    logic        hang;
    int          ucnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.md_clear_o) begin
            bus.md_busy_i       <= 1'b0;
            bus.md_data_ready_i <= 1'b0;
            bus.md_result_i     <= '0;
            ucnt                <= 0;
        end else if (bus.md_writeback_ce_o) begin
            bus.md_data_ready_i <= 1'b0;
        end else if (bus.md_data_ready_o) begin
            bus.md_busy_i       <= 1'b1;
            bus.md_data_ready_i <= 1'b0;
            ucnt                <= unit_lat;
        end else if (bus.md_busy_i && !hang) begin
            if (ucnt == 0) begin
                bus.md_busy_i       <= 1'b0;
                bus.md_data_ready_i <= 1'b1;
                bus.md_result_i     <= unit_result;
            end else begin
                ucnt <= ucnt - 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, required finish before 500us");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] f, input logic [4:0] rd, input logic [31:0] a,
                         input logic [31:0] b);
        bus.issue_valid_i = 1'b1;
        bus.funct3_i      = f;
        bus.rd_i          = rd;
        bus.rs1_i         = a;
        bus.rs2_i         = b;
        step();
        bus.issue_valid_i = 1'b0;
    endtask

    task automatic wait_wb(input int budget, output int got, output int wb_at, output int rdy_at,
                           output int dr_pulses, output int stall_lo);
        got = 0; wb_at = -1; rdy_at = -1; dr_pulses = 0; stall_lo = 0;
        for (int i = 1; i <= budget && got == 0; i++) begin
            step();
            if (bus.md_data_ready_o) dr_pulses++;
            if (bus.md_data_ready_i && rdy_at < 0) rdy_at = i;
            if (!bus.stall_o) stall_lo++;
            if (bus.wb_valid_o) begin
                got   = 1;
                wb_at = i;
            end
        end
    endtask

    int got, wb_at, rdy_at, drp, stl;
    int n_wb, n_ce, n_dr;

    initial begin
        bus.flush_i = 1'b0; bus.issue_valid_i = 1'b0; bus.funct3_i = '0; bus.rd_i = '0;
        bus.rs1_i = '0; bus.rs2_i = '0; bus.wb_ack_i = 1'b0;
        unit_result = '0; unit_lat = 3; hang = 1'b0;
        clear = 1'b1;
        step();
        step();
        check("rst_issue_ready", bus.issue_ready_o, 1);
        check("rst_md_clear", bus.md_clear_o, 1);
        check("rst_stall", bus.stall_o, 0);
        check("rst_wb_valid", bus.wb_valid_o, 0);
        check("rst_error", bus.error_o, 0);
        check("rst_md_data_ready", bus.md_data_ready_o, 0);
        check("rst_wb_data", bus.wb_data_o, 0);
        clear = 1'b0;
        step();
        check("post_rst_md_clear", bus.md_clear_o, 0);

        // DIVU 100/7 -> 14, ack tied high
        bus.wb_ack_i = 1'b1;
        unit_result  = 32'd14;
        issue(3'b101, 5'd5, 32'd100, 32'd7);
        check("divu_dr_t1", bus.md_data_ready_o, 1);
        check("divu_stall", bus.stall_o, 1);
        check("divu_not_ready", bus.issue_ready_o, 0);
        check("divu_md_op", bus.md_operation_o, 3'b101);
        check("divu_md_opnd1", bus.md_operand1_o, 100);
        check("divu_md_opnd2", bus.md_operand2_o, 7);
        wait_wb(40, got, wb_at, rdy_at, drp, stl);
        check("divu_wb_seen", got, 1);
        check("divu_dr_single", drp, 0);
        check("divu_wb_after_ready", 32'(wb_at - rdy_at), 1);
        check("divu_wb_rd", bus.wb_rd_o, 5);
        check("divu_wb_data", bus.wb_data_o, 14);
        check("divu_ce", bus.md_writeback_ce_o, 1);
        step();
        check("divu_ce_single", bus.md_writeback_ce_o, 0);
        check("divu_wb_drop", bus.wb_valid_o, 0);
        check("divu_ready_back", bus.issue_ready_o, 1);

        // REM -7 % 2 -> -1, ack delayed 3 cycles
        bus.wb_ack_i = 1'b0;
        unit_result  = 32'hFFFF_FFFF;
        issue(3'b110, 5'd3, 32'hFFFF_FFF9, 32'd2);
        check("rem_stall_t1", bus.stall_o, 1);
        wait_wb(40, got, wb_at, rdy_at, drp, stl);
        check("rem_wb_seen", got, 1);
        check("rem_stall_throughout", stl, 0);
        for (int k = 0; k < 3; k++) begin
            check("rem_hold_valid", bus.wb_valid_o, 1);
            check("rem_hold_data", bus.wb_data_o, 32'hFFFF_FFFF);
            check("rem_hold_rd", bus.wb_rd_o, 3);
            check("rem_hold_stall", bus.stall_o, 1);
            check("rem_hold_no_ce", bus.md_writeback_ce_o, 0);
            step();
        end
        bus.wb_ack_i = 1'b1;
        #1;
        check("rem_ack_valid", bus.wb_valid_o, 1);
        check("rem_ack_data", bus.wb_data_o, 32'hFFFF_FFFF);
        check("rem_ack_ce", bus.md_writeback_ce_o, 1);
        step();
        bus.wb_ack_i = 1'b0;
        check("rem_ce_single", bus.md_writeback_ce_o, 0);
        check("rem_ready_back", bus.issue_ready_o, 1);

        // MUL with rd=x0 is dropped
        issue(3'b000, 5'd0, 32'd6, 32'd7);
        check("x0_no_dr", bus.md_data_ready_o, 0);
        check("x0_no_wb", bus.wb_valid_o, 0);
        check("x0_not_ready_t1", bus.issue_ready_o, 0);
        step();
        check("x0_ready_t2", bus.issue_ready_o, 1);
        check("x0_no_wb_t2", bus.wb_valid_o, 0);
        check("x0_unit_idle", bus.md_busy_i, 0);

        // DIV flushed 5 cycles into WAIT_DONE
        unit_lat    = 20;
        unit_result = 32'd14;
        issue(3'b100, 5'd4, 32'd100, 32'd7);
        for (int k = 0; k < 7; k++) step();
        check("flush_pre_stall", bus.stall_o, 1);
        check("flush_pre_busy", bus.md_busy_i, 1);
        bus.flush_i = 1'b1;
        #1;
        check("flush_cycle_no_wb", bus.wb_valid_o, 0);
        step();
        bus.flush_i = 1'b0;
        check("flush_md_clear", bus.md_clear_o, 1);
        check("flush_idle", bus.issue_ready_o, 1);
        check("flush_stall_low", bus.stall_o, 0);
        step();
        check("flush_md_clear_single", bus.md_clear_o, 0);
        n_wb = 0; n_ce = 0; n_dr = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.wb_valid_o) n_wb++;
            if (bus.md_writeback_ce_o) n_ce++;
            if (bus.md_data_ready_o) n_dr++;
        end
        check("flush_never_wb", n_wb, 0);
        check("flush_never_ce", n_ce, 0);
        check("flush_never_dr", n_dr, 0);

        // Hung unit -> watchdog
        hang     = 1'b1;
        unit_lat = 3;
        issue(3'b011, 5'd7, 32'd1, 32'd2);
        wait_wb(200, got, wb_at, rdy_at, drp, stl);
        check("wd_wb_seen", got, 1);
        check("wd_latency", wb_at, 65);
        check("wd_error", bus.error_o, 1);
        check("wd_md_clear", bus.md_clear_o, 1);
        check("wd_wb_data", bus.wb_data_o, 32'hFFFF_FFFF);
        check("wd_wb_rd", bus.wb_rd_o, 7);
        bus.wb_ack_i = 1'b1;
        step();
        bus.wb_ack_i = 1'b0;
        hang = 1'b0;
        check("wd_ready_back", bus.issue_ready_o, 1);
        check("wd_md_clear_single", bus.md_clear_o, 0);
        step();
        check("wd_error_sticky", bus.error_o, 1);

        // clear mid-operation
        unit_lat = 20;
        issue(3'b001, 5'd9, 32'd5, 32'd6);
        step();
        step();
        check("clr_pre_stall", bus.stall_o, 1);
        clear = 1'b1;
        step();
        check("clr_idle", bus.issue_ready_o, 1);
        check("clr_stall", bus.stall_o, 0);
        check("clr_error", bus.error_o, 0);
        check("clr_opnd1", bus.md_operand1_o, 0);
        check("clr_wb_rd", bus.wb_rd_o, 0);
        check("clr_md_clear", bus.md_clear_o, 1);
        clear = 1'b0;
        step();
        check("clr_md_clear_drop", bus.md_clear_o, 0);

`ifdef MULDIV_RESULT_CACHE_EN
        unit_lat     = 3;
        unit_result  = 32'd42;
        bus.wb_ack_i = 1'b1;
        issue(3'b000, 5'd1, 32'd6, 32'd7);
        wait_wb(40, got, wb_at, rdy_at, drp, stl);
        check("cache_fill_wb", bus.wb_data_o, 42);
        step();
        issue(3'b000, 5'd2, 32'd6, 32'd7);
        check("cache_hit_wb", bus.wb_valid_o, 1);
        check("cache_hit_data", bus.wb_data_o, 42);
        check("cache_hit_rd", bus.wb_rd_o, 2);
        check("cache_hit_no_dr", bus.md_data_ready_o, 0);
        check("cache_hit_no_ce", bus.md_writeback_ce_o, 0);
        step();
        check("cache_hit_ready", bus.issue_ready_o, 1);
        bus.wb_ack_i = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
